// File: rtl/cache_4way_pkg.sv
// Shared types and size constants for the 4-way write-through data cache.
// Build option: CACHE_4WAY_STATS_EN adds saturating hit/miss counters to cache_4way.
package cache_4way_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int SETS_DEF   = 4;
  localparam int WAYS       = 4;
  localparam int DATA_W     = 32;
  localparam int IDX_W      = $clog2(SETS_DEF);
  localparam int TAG_W      = ADDR_W_DEF - IDX_W;
  localparam int WAY_W      = $clog2(WAYS);

  typedef logic [1:0]       age_t;
  typedef logic [WAY_W-1:0] way_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } line_t;

endpackage

// File: rtl/cache_4way_lru.sv
// Per-set LRU age tracker; picks the victim way for a fill (lowest invalid way, else oldest).
module cache_4way_lru
  import cache_4way_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_touch,
  input  way_t            i_way,
  input  logic [WAYS-1:0] i_valid,
  output way_t            o_victim
);

  age_t r_age [WAYS];
  age_t w_old;

  assign w_old = r_age[i_way];

  // Ages stay a permutation of 0..3: only ways younger than the touched one move back.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WAYS; i++) r_age[i] <= age_t'(i);
    end else if (i_touch) begin
      for (int i = 0; i < WAYS; i++) begin
        if (way_t'(i) == i_way)  r_age[i] <= '0;
        else if (r_age[i] < w_old) r_age[i] <= r_age[i] + age_t'(1);
      end
    end
  end

  always_comb begin
    o_victim = '0;
    for (int i = 0; i < WAYS; i++)
      if (r_age[i] == age_t'(3)) o_victim = way_t'(i);
    for (int i = WAYS - 1; i >= 0; i--)
      if (!i_valid[i]) o_victim = way_t'(i);
  end

endmodule

// File: rtl/cache_4way.sv
// Four-way set-associative write-through/write-allocate cache with a 128-word backing memory.
// Build option: define CACHE_4WAY_STATS_EN to add hit_count/miss_count outputs.
module cache_4way
  import cache_4way_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int SETS   = SETS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic [31:0] addr,
  input  logic        wr,
  output logic [31:0] out,
  output logic        response,
  output logic        is_missrate
`ifdef CACHE_4WAY_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [ADDR_W-1:0] w_maddr;
  logic [WAYS-1:0]   w_hit_vec;
  logic              w_hit;
  way_t              w_hit_way;
  way_t              w_way;
  way_t              w_victim [SETS];
  logic [WAYS-1:0]   w_valid  [SETS];
  logic [31:0]       w_mem_rd;
  logic [31:0]       w_wdata;
  logic              w_unused_addr;

  line_t       r_lines [SETS][WAYS];
  // Memory contents survive rst; power-up value is all-zero.
  logic [31:0] r_mem [2**ADDR_W] = '{default: '0};

  assign w_idx         = addr[IDX_W-1:0];
  assign w_tag         = addr[IDX_W +: TAG_W];
  assign w_maddr       = addr[ADDR_W-1:0];
  assign w_mem_rd      = r_mem[w_maddr];
  assign w_unused_addr = ^addr[31:ADDR_W];

  // Lookup stage
  always_comb begin
    w_hit_vec = '0;
    w_hit_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      w_hit_vec[i] = r_lines[w_idx][i].valid && (r_lines[w_idx][i].tag == w_tag);
      if (w_hit_vec[i]) w_hit_way = way_t'(i);
    end
    w_hit   = |w_hit_vec;
    w_way   = w_hit ? w_hit_way : w_victim[w_idx];
    w_wdata = wr ? data : (w_hit ? r_lines[w_idx][w_hit_way].data : w_mem_rd);
  end

  for (genvar s = 0; s < SETS; s++) begin : g_set
    for (genvar i = 0; i < WAYS; i++) begin : g_way
      assign w_valid[s][i] = r_lines[s][i].valid;
    end
    cache_4way_lru u_lru (
      .clk      (clk),
      .rst      (rst),
      .i_touch  (w_idx == IDX_W'(s)),
      .i_way    (w_way),
      .i_valid  (w_valid[s]),
      .o_victim (w_victim[s])
    );
  end

  // A read hit rewrites the line with its own data, keeping one write path for all cases.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++)
        for (int i = 0; i < WAYS; i++) r_lines[s][i].valid <= 1'b0;
    end else begin
      r_lines[w_idx][w_way] <= '{valid: 1'b1, tag: w_tag, data: w_wdata};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr) r_mem[w_maddr] <= data;
  end

  // Registered response stage
  always_ff @(posedge clk) begin
    if (rst) begin
      out         <= '0;
      response    <= 1'b0;
      is_missrate <= 1'b0;
    end else begin
      out         <= w_wdata;
      response    <= 1'b1;
      is_missrate <= !w_hit;
    end
  end

`ifdef CACHE_4WAY_STATS_EN
  logic [15:0] r_hit_count;
  logic [15:0] r_miss_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (w_hit) begin
      if (r_hit_count != 16'hFFFF) r_hit_count <= r_hit_count + 16'd1;
    end else begin
      if (r_miss_count != 16'hFFFF) r_miss_count <= r_miss_count + 16'd1;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_cache_4way.sv
// Randomized bench for cache_4way against a recency-list model of the cache and a flat memory model.
module tb_cache_4way;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data = '0;
  logic [31:0] addr = '0;
  logic        wr = 1'b0;
  logic [31:0] out;
  logic        response;
  logic        is_missrate;
`ifdef CACHE_4WAY_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  cache_4way dut (
    .clk         (clk),
    .rst         (rst),
    .data        (data),
    .addr        (addr),
    .wr          (wr),
    .out         (out),
    .response    (response),
    .is_missrate (is_missrate)
`ifdef CACHE_4WAY_STATS_EN
    ,
    .hit_count   (hit_count),
    .miss_count  (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Model: each set is a list of resident tags, most recently used first, at most 4 long.
  logic [31:0] m_mem [128];
  int          m_set [4][$];
  int unsigned m_hits;
  int unsigned m_misses;

  function automatic void model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                                       output logic hit, output logic [31:0] eo);
    int s   = int'(a[1:0]);
    int t   = int'(a[6:2]);
    int pos = -1;
    for (int k = 0; k < m_set[s].size(); k++)
      if (m_set[s][k] == t) pos = k;
    hit = (pos >= 0);
    if (hit) m_set[s].delete(pos);
    else if (m_set[s].size() == 4) void'(m_set[s].pop_back());
    m_set[s].push_front(t);
    if (w) m_mem[a[6:0]] = d;
    eo = w ? d : m_mem[a[6:0]];
    if (hit) begin if (m_hits < 65535) m_hits++; end
    else begin if (m_misses < 65535) m_misses++; end
  endfunction

  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic        h;
    logic [31:0] eo;
    wr   = w;
    addr = a;
    data = d;
    model_access(w, a, d, h, eo);
    @(posedge clk);
    #1;
    check("out", out, eo);
    check("response", {31'b0, response}, 32'd1);
    check("is_missrate", {31'b0, is_missrate}, {31'b0, !h});
`ifdef CACHE_4WAY_STATS_EN
    check("hit_count", {16'b0, hit_count}, m_hits);
    check("miss_count", {16'b0, miss_count}, m_misses);
`endif
  endtask

  // The access presented during reset must be dropped entirely.
  task automatic do_reset(input logic w, input logic [31:0] a, input logic [31:0] d);
    wr   = w;
    addr = a;
    data = d;
    rst  = 1'b1;
    @(posedge clk);
    #1;
    check("rst_out", out, 32'd0);
    check("rst_response", {31'b0, response}, 32'd0);
    check("rst_is_missrate", {31'b0, is_missrate}, 32'd0);
`ifdef CACHE_4WAY_STATS_EN
    check("rst_hit_count", {16'b0, hit_count}, 32'd0);
    check("rst_miss_count", {16'b0, miss_count}, 32'd0);
`endif
    rst = 1'b0;
    for (int s = 0; s < 4; s++) m_set[s].delete();
    m_hits   = 0;
    m_misses = 0;
  endtask

  initial begin
    logic [31:0] a;
    int unsigned r;
    for (int i = 0; i < 128; i++) m_mem[i] = '0;
    m_hits   = 0;
    m_misses = 0;

    do_reset(1'b0, 32'd0, 32'd0);

    access(1'b0, 32'd5, 32'd0);
    check("tp_rd5_miss", {31'b0, is_missrate}, 32'd1);
    check("tp_rd5_out", out, 32'd0);
    access(1'b0, 32'd5, 32'd0);
    check("tp_rd5_hit", {31'b0, is_missrate}, 32'd0);

    access(1'b1, 32'd3, 32'd2);
    check("tp_wr3_miss", {31'b0, is_missrate}, 32'd1);
    check("tp_wr3_out", out, 32'd2);
    access(1'b0, 32'd3, 32'd0);
    check("tp_rd3_out", out, 32'd2);
    access(1'b1, 32'd3, 32'd1);
    check("tp_wr3_hit", {31'b0, is_missrate}, 32'd0);
    access(1'b0, 32'd3, 32'd0);
    check("tp_rd3_new", out, 32'd1);

    access(1'b0, 32'd0, 32'd0);
    access(1'b0, 32'd4, 32'd0);
    access(1'b0, 32'd8, 32'd0);
    access(1'b0, 32'd12, 32'd0);
    access(1'b0, 32'd0, 32'd0);
    check("tp_set0_rehit", {31'b0, is_missrate}, 32'd0);
    access(1'b0, 32'd16, 32'd0);
    check("tp_set0_fill16", {31'b0, is_missrate}, 32'd1);
    access(1'b0, 32'd4, 32'd0);
    check("tp_evicted4", {31'b0, is_missrate}, 32'd1);
    access(1'b0, 32'd0, 32'd0);
    check("tp_kept0", {31'b0, is_missrate}, 32'd0);

    access(1'b1, 32'd9, 32'hDEADBEEF);
    do_reset(1'b1, 32'd9, 32'h12345678);
    access(1'b0, 32'd9, 32'd0);
    check("tp_rd9_miss", {31'b0, is_missrate}, 32'd1);
    check("tp_rd9_mem", out, 32'hDEADBEEF);

    do_reset(1'b0, 32'd0, 32'd0);
    access(1'b0, 32'd20, 32'd0);
    access(1'b0, 32'd20, 32'd0);
    access(1'b0, 32'd20, 32'd0);
    access(1'b0, 32'd21, 32'd0);
`ifdef CACHE_4WAY_STATS_EN
    check("tp_stats_hits", {16'b0, hit_count}, 32'd2);
    check("tp_stats_misses", {16'b0, miss_count}, 32'd2);
`endif
    do_reset(1'b1, 32'd21, 32'hFFFF0000);
    access(1'b0, 32'd21, 32'd0);
    check("tp_dropped_wr", out, 32'd0);

    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 99);
      a = ($urandom & 32'hFFFF_FF80) | 32'($urandom_range(0, 47));
      if (r < 2) do_reset(1'b1, a, $urandom);
      else       access(r < 35, a, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
